serial_adder: RTL

Bit-serial adder: accepts two WIDTH-bit operands plus carry-in on a start strobe, then adds them LSB-first over WIDTH clock cycles. Each cycle uses a single one-bit full-adder cell and a registered carry. It produces a registered WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits downstream of operand generation, where the combinational full adder is the per-bit datapath. It trades latency for area against a ripple adder.

---
 rtl/serial_adder_pkg.sv | 11 +
 rtl/serial_adder_fa.sv | 17 +
 rtl/serial_adder.sv | 111 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types for the bit-serial adder.
//   state_t : controller state (IDLE, SHIFT, DONE), 2-bit encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// full_adder_cell: purely combinational one-bit full adder.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit  (a ^ b ^ cin)
//   co   : carry out (majority of a, b, cin)
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first, one full-adder cell per cycle.
//   clk   : clock, all state on rising edge
//   rst   : synchronous active-high reset
//   start : request, sampled only in IDLE
//   a, b  : WIDTH-bit operands, captured on accepted start
//   cin   : carry in, captured on accepted start
//   busy  : high while in SHIFT or DONE
//   done  : one-cycle pulse when sum/cout hold a new result
//   sum   : result register, holds until the next result
//   cout  : carry-out register, holds with sum
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_bit;
  logic             w_carry;

  full_adder_cell u_fa (
    .a   (r_a_sh[0]),
    .b   (r_b_sh[0]),
    .cin (r_carry),
    .s   (w_bit),
    .co  (w_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_carry <= w_carry;
          r_acc   <= {w_bit, r_acc[WIDTH-1:1]};
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_cnt   <= r_cnt + CW'(1);
          // Last bit: the accumulator is not yet shifted, so the result is
          // assembled from the fresh bit plus the W-1 bits already collected.
          if (r_cnt == CNT_LAST) begin
            r_sum   <= {w_bit, r_acc[WIDTH-1:1]};
            r_cout  <= w_carry;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
